ipsxb_sync_fifo_v2_0: RTL and testbench

IPSXB_SYNC_FIFO_V2_0 -- requirements
Module: ipsxb_sync_fifo_v2_0

---
 rtl/ipsxb_fifo_pkg.sv | 20 ++
 rtl/ipsxb_sdp_ram_v2_0.sv | 55 +++++
 rtl/ipsxb_sync_fifo_v2_0.sv | 168 ++++++++++++++++
 tb/tb_ipsxb_sync_fifo_v2_0.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsxb_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipsxb_fifo_pkg
// Description : Shared constants for the ipsxb synchronous FIFO family.
//               Holds the read-mode selector strings and the supported
//               address-width limits.
// Revision    : v2.0 - initial release
// ============================================================================
package ipsxb_fifo_pkg;

    // Read-mode selector values for the FIFO RD_MODE parameter
    localparam string c_RD_MODE_STANDARD = "STANDARD";
    localparam string c_RD_MODE_FWFT     = "FWFT";

    // Supported range of the FIFO ADDR_WIDTH parameter
    localparam int c_ADDR_WIDTH_MIN = 4;
    localparam int c_ADDR_WIDTH_MAX = 10;

endpackage : ipsxb_fifo_pkg
`default_nettype wire

// File: rtl/ipsxb_sdp_ram_v2_0.sv
`default_nettype none
// ============================================================================
// Module      : ipsxb_sdp_ram_v2_0
// Description : Simple dual-port distributed RAM. One synchronous write port
//               and one read port whose output register is loaded only when
//               i_rd_en is high, so the last read word is held otherwise.
//               The output register clears on rst; the array itself does not.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset (output reg only)
//               i_wr_en    - write strobe
//               i_wr_addr  - write address
//               i_wr_data  - write data
//               i_rd_en    - read strobe (loads the output register)
//               i_rd_addr  - read address
//               o_rd_data  - registered read data
// Revision    : v2.0 - initial release
// ============================================================================
module ipsxb_sdp_ram_v2_0
    import ipsxb_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage array: no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : ipsxb_sdp_ram_v2_0
`default_nettype wire

// File: rtl/ipsxb_sync_fifo_v2_0.sv
`default_nettype none
// ============================================================================
// Module      : ipsxb_sync_fifo_v2_0
// Description : Single-clock FIFO with STANDARD or first-word-fall-through
//               read mode, registered full/empty/almost flags and a
//               registered fill level. Storage is ipsxb_sdp_ram_v2_0.
//               Optional sticky overflow/underflow flags are compiled in
//               when the macro IPSXB_FIFO_ERR_FLAG_EN is defined.
// Ports       : clk, rst          - clock and synchronous active-high reset
//               w_en, wr_data     - write request and data
//               r_en              - read (STANDARD) / pop (FWFT) request
//               rd_data, rd_valid - read data and its qualifier
//               af_thresh         - almost_full when level >= threshold
//               ae_thresh         - almost_empty when level <= threshold
//               wfull, almost_full, rempty, almost_empty - status flags
//               water_level       - number of words held (0..2^ADDR_WIDTH)
//               overflow          - sticky, write attempted while full
//               underflow         - sticky, read attempted while empty
// Revision    : v2.0 - initial release
// ============================================================================
module ipsxb_sync_fifo_v2_0
    import ipsxb_fifo_pkg::*;
#(
    parameter int    ADDR_WIDTH = 9,
    parameter int    DATA_WIDTH = 16,
    parameter string RD_MODE    = "STANDARD"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  wfull,
    output logic                  almost_full,
    output logic                  rempty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level
`ifdef IPSXB_FIFO_ERR_FLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam bit                  c_FWFT       = (RD_MODE == c_RD_MODE_FWFT);
    localparam logic [ADDR_WIDTH:0] c_FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] r_wptr;
    logic [ADDR_WIDTH:0] r_rptr;
    logic [ADDR_WIDTH:0] r_level;
    logic                r_wfull;
    logic                r_almost_full;
    logic                r_rempty;
    logic                r_almost_empty;
    logic                r_rd_valid;
    logic                r_head_valid;   // FWFT: RAM output register holds the head word

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_ram_has_data;
    logic                w_ram_rd;
    logic                w_head_valid_nxt;
    logic [ADDR_WIDTH:0] w_level_nxt;

    assign w_wr_acc       = w_en && !r_wfull;
    assign w_rd_acc       = r_en && !r_rempty;
    // Words written to the array but not yet read out of it
    assign w_ram_has_data = (r_wptr != r_rptr);

    // In FWFT the RAM output register acts as the head-of-queue register:
    // it is refilled whenever it is empty or being popped and the array has
    // a word to give. In STANDARD the array is read only on an accepted read.
    always_comb begin
        w_ram_rd         = 1'b0;
        w_head_valid_nxt = 1'b0;
        if (c_FWFT) begin
            w_ram_rd         = w_ram_has_data && (!r_head_valid || w_rd_acc);
            w_head_valid_nxt = w_ram_rd || (r_head_valid && !w_rd_acc);
        end else begin
            w_ram_rd         = w_rd_acc;
        end
    end

    // Level counts every word owned by the FIFO, including the FWFT head word
    assign w_level_nxt = r_level
                       + {{ADDR_WIDTH{1'b0}}, w_wr_acc}
                       - {{ADDR_WIDTH{1'b0}}, w_rd_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_wfull        <= 1'b0;
            r_almost_full  <= 1'b0;
            r_rempty       <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_valid     <= 1'b0;
            r_head_valid   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_ram_rd) begin
                r_rptr <= r_rptr + c_ONE;
            end
            r_level        <= w_level_nxt;
            r_wfull        <= (w_level_nxt == c_FULL_LEVEL);
            r_almost_full  <= (w_level_nxt >= af_thresh);
            r_almost_empty <= (w_level_nxt <= ae_thresh);
            r_head_valid   <= w_head_valid_nxt;
            // FWFT empty tracks the head register, so a freshly written word
            // is counted in the level one cycle before it becomes readable
            r_rempty       <= c_FWFT ? !w_head_valid_nxt : (w_level_nxt == '0);
            r_rd_valid     <= c_FWFT ?  w_head_valid_nxt : w_rd_acc;
        end
    end

    ipsxb_sdp_ram_v2_0 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rd_data (rd_data)
    );

    assign rd_valid     = r_rd_valid;
    assign wfull        = r_wfull;
    assign almost_full  = r_almost_full;
    assign rempty       = r_rempty;
    assign almost_empty = r_almost_empty;
    assign water_level  = r_level;

`ifdef IPSXB_FIFO_ERR_FLAG_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && r_wfull) begin
                r_overflow <= 1'b1;
            end
            if (r_en && r_rempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule : ipsxb_sync_fifo_v2_0
`default_nettype wire

// File: tb/tb_ipsxb_sync_fifo_v2_0.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipsxb_sync_fifo_v2_0
// Description : Bench for ipsxb_sync_fifo_v2_0. One STANDARD and one FWFT
//               instance (ADDR_WIDTH=4, DATA_WIDTH=8) are compared every
//               cycle against a queue-based reference model; a vector table
//               and directed sequences add fixed expected values.
//               Honours IPSXB_FIFO_ERR_FLAG_EN for the error flags.
// Revision    : v2.0 - initial release
// ============================================================================
module tb_ipsxb_sync_fifo_v2_0;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   af_thresh = 5'd14;
    logic [AW:0]   ae_thresh = 5'd2;

    logic          s_w_en = 1'b0, s_r_en = 1'b0;
    logic [DW-1:0] s_wr_data = '0;
    logic [DW-1:0] s_rd_data;
    logic          s_rd_valid, s_wfull, s_af, s_rempty, s_ae;
    logic [AW:0]   s_level;

    logic          f_w_en = 1'b0, f_r_en = 1'b0;
    logic [DW-1:0] f_wr_data = '0;
    logic [DW-1:0] f_rd_data;
    logic          f_rd_valid, f_wfull, f_af, f_rempty, f_ae;
    logic [AW:0]   f_level;

`ifdef IPSXB_FIFO_ERR_FLAG_EN
    logic s_ovf, s_unf, f_ovf, f_unf;
    bit   m_s_ovf, m_s_unf, m_f_ovf, m_f_unf;
`endif

    always #5 clk = ~clk;

    ipsxb_sync_fifo_v2_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_MODE("STANDARD")) u_std (
        .clk(clk), .rst(rst), .w_en(s_w_en), .wr_data(s_wr_data), .r_en(s_r_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .wfull(s_wfull), .almost_full(s_af), .rempty(s_rempty), .almost_empty(s_ae),
        .water_level(s_level)
`ifdef IPSXB_FIFO_ERR_FLAG_EN
        , .overflow(s_ovf), .underflow(s_unf)
`endif
    );

    ipsxb_sync_fifo_v2_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_MODE("FWFT")) u_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .wr_data(f_wr_data), .r_en(f_r_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .wfull(f_wfull), .almost_full(f_af), .rempty(f_rempty), .almost_empty(f_ae),
        .water_level(f_level)
`ifdef IPSXB_FIFO_ERR_FLAG_EN
        , .overflow(f_ovf), .underflow(f_unf)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // STANDARD: a plain queue; read data is the word popped at the last edge.
    // FWFT: each word carries the edge index of its write and may only be
    // presented at a later edge; the head is presented when it exists and
    // was written at an earlier edge.
    typedef struct { logic [DW-1:0] data; int stamp; } fent_t;

    logic [DW-1:0] sq[$];
    fent_t         fq[$];
    logic [DW-1:0] m_s_last = '0, m_f_last = '0;
    bit            m_s_rv, m_s_af, m_s_ae = 1'b1;
    bit            m_f_hv, m_f_af, m_f_ae = 1'b1;
    int            edge_n = 0;

    task automatic model_edge();
        bit full_b, wacc, racc;
        edge_n++;
        if (rst) begin
            sq.delete(); fq.delete();
            m_s_last = '0; m_s_rv = 0; m_s_af = 0; m_s_ae = 1;
            m_f_last = '0; m_f_hv = 0; m_f_af = 0; m_f_ae = 1;
`ifdef IPSXB_FIFO_ERR_FLAG_EN
            m_s_ovf = 0; m_s_unf = 0; m_f_ovf = 0; m_f_unf = 0;
`endif
        end else begin
            full_b = (sq.size() == DEPTH);
            wacc   = s_w_en && !full_b;
            racc   = s_r_en && (sq.size() != 0);
`ifdef IPSXB_FIFO_ERR_FLAG_EN
            if (s_w_en && full_b)        m_s_ovf = 1;
            if (s_r_en && sq.size() == 0) m_s_unf = 1;
`endif
            m_s_rv = racc;
            if (racc) m_s_last = sq.pop_front();
            if (wacc) sq.push_back(s_wr_data);
            m_s_af = (sq.size() >= int'(af_thresh));
            m_s_ae = (sq.size() <= int'(ae_thresh));

            full_b = (fq.size() == DEPTH);
            wacc   = f_w_en && !full_b;
            racc   = f_r_en && m_f_hv;
`ifdef IPSXB_FIFO_ERR_FLAG_EN
            if (f_w_en && full_b)  m_f_ovf = 1;
            if (f_r_en && !m_f_hv) m_f_unf = 1;
`endif
            if (racc) void'(fq.pop_front());
            if (wacc) fq.push_back('{data: f_wr_data, stamp: edge_n});
            m_f_hv = (fq.size() > 0) && (fq[0].stamp < edge_n);
            if (m_f_hv) m_f_last = fq[0].data;
            m_f_af = (fq.size() >= int'(af_thresh));
            m_f_ae = (fq.size() <= int'(ae_thresh));
        end
    endtask

    task automatic check_all();
        chk("std.level",        s_level,    sq.size());
        chk("std.wfull",        s_wfull,    sq.size() == DEPTH);
        chk("std.rempty",       s_rempty,   sq.size() == 0);
        chk("std.almost_full",  s_af,       m_s_af);
        chk("std.almost_empty", s_ae,       m_s_ae);
        chk("std.rd_valid",     s_rd_valid, m_s_rv);
        chk("std.rd_data",      s_rd_data,  m_s_last);
        chk("fwft.level",       f_level,    fq.size());
        chk("fwft.wfull",       f_wfull,    fq.size() == DEPTH);
        chk("fwft.rempty",      f_rempty,   !m_f_hv);
        chk("fwft.rd_valid",    f_rd_valid, m_f_hv);
        chk("fwft.rd_data",     f_rd_data,  m_f_last);
        chk("fwft.almost_full", f_af,       m_f_af);
        chk("fwft.almost_empty",f_ae,       m_f_ae);
`ifdef IPSXB_FIFO_ERR_FLAG_EN
        chk("std.overflow",     s_ovf,      m_s_ovf);
        chk("std.underflow",    s_unf,      m_s_unf);
        chk("fwft.overflow",    f_ovf,      m_f_ovf);
        chk("fwft.underflow",   f_unf,      m_f_unf);
`endif
    endtask

    // One clock: inputs were set beforehand, model advances on the edge,
    // outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        s_w_en = 0; s_r_en = 0; f_w_en = 0; f_r_en = 0;
    endtask

    // ---------------- directed vector table (STANDARD instance) ----------------
    typedef struct {
        bit rst; bit we; bit re; logic [DW-1:0] d;
        int lvl; bit full; bit empty; bit aempty; bit rv; logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int wp, rp;

        //           rst we re data   lvl full emp ae rv rd
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h22, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h33, 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44};

        foreach (tbl[i]) begin
            rst = tbl[i].rst; s_w_en = tbl[i].we; s_r_en = tbl[i].re; s_wr_data = tbl[i].d;
            step();
            chk($sformatf("tbl%0d.level", i),  s_level,    tbl[i].lvl);
            chk($sformatf("tbl%0d.wfull", i),  s_wfull,    tbl[i].full);
            chk($sformatf("tbl%0d.rempty", i), s_rempty,   tbl[i].empty);
            chk($sformatf("tbl%0d.aempty", i), s_ae,       tbl[i].aempty);
            chk($sformatf("tbl%0d.rvalid", i), s_rd_valid, tbl[i].rv);
            chk($sformatf("tbl%0d.rdata", i),  s_rd_data,  tbl[i].rd);
        end
        idle_inputs();

        // ---- fill STANDARD to full, watch almost_full and wfull ----
        rst = 1; step(); rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            s_w_en = 1; s_wr_data = 8'(i);
            step();
            chk("fill.level",       s_level, i + 1);
            chk("fill.almost_full", s_af,    (i + 1) >= 14);
            chk("fill.wfull",       s_wfull, i == DEPTH - 1);
        end

        // ---- full: simultaneous write+read, write dropped ----
        s_w_en = 1; s_r_en = 1; s_wr_data = 8'hEE;
        step();
        idle_inputs();
        chk("fullrw.rd_data",  s_rd_data,  8'h00);
        chk("fullrw.rd_valid", s_rd_valid, 1'b1);
        chk("fullrw.level",    s_level,    15);
        chk("fullrw.wfull",    s_wfull,    1'b0);
`ifdef IPSXB_FIFO_ERR_FLAG_EN
        chk("fullrw.overflow", s_ovf,      1'b1);
`endif
        for (int i = 1; i < DEPTH; i++) begin
            s_r_en = 1;
            step();
            chk("drain.rd_data", s_rd_data, 8'(i));
        end
        idle_inputs();
        step();
        chk("drain.rempty", s_rempty, 1'b1);

        // ---- FWFT single word latency ----
        f_w_en = 1; f_wr_data = 8'hA5;
        step();
        f_w_en = 0;
        chk("fwft1.rempty_d1", f_rempty, 1'b1);
        chk("fwft1.level_d1",  f_level,  1);
        step();
        chk("fwft1.rempty_d2", f_rempty,   1'b0);
        chk("fwft1.rd_data",   f_rd_data,  8'hA5);
        chk("fwft1.rd_valid",  f_rd_valid, 1'b1);
        f_r_en = 1;
        step();
        f_r_en = 0;
        chk("fwft1.pop_rempty", f_rempty, 1'b1);
        chk("fwft1.pop_level",  f_level,  0);

        // ---- pointer wrap with alternating write/read ----
        for (int k = 0; k < 40; k++) begin
            s_w_en = 1; s_r_en = 0; s_wr_data = 8'(k + 64);
            f_w_en = 1; f_r_en = 0; f_wr_data = 8'(k + 64);
            step();
            chk("wrap.level_w", s_level, 1);
            chk("wrap.wfull",   s_wfull, 1'b0);
            s_w_en = 0; s_r_en = 1;
            f_w_en = 0; f_r_en = 1;
            step();
            chk("wrap.level_r", s_level,   0);
            chk("wrap.rd_data", s_rd_data, 8'(k + 64));
        end
        idle_inputs();
        step(); step();

        // ---- reset mid-operation ----
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 9; i++) begin
            s_w_en = 1; s_wr_data = 8'(i + 200);
            f_w_en = 1; f_wr_data = 8'(i + 200);
            step();
        end
        idle_inputs();
        chk("rst9.level_pre", s_level, 9);
        rst = 1; s_w_en = 1; s_r_en = 1; f_w_en = 1; f_r_en = 1;
        step();
        rst = 0; idle_inputs();
        chk("rst9.std_level",   s_level,  0);
        chk("rst9.std_rempty",  s_rempty, 1'b1);
        chk("rst9.std_aempty",  s_ae,     1'b1);
        chk("rst9.fwft_level",  f_level,  0);
        chk("rst9.fwft_rempty", f_rempty, 1'b1);
        s_r_en = 1; f_r_en = 1;
        step();
        idle_inputs();
        chk("rst9.std_rd_valid",  s_rd_valid, 1'b0);
        chk("rst9.fwft_rd_valid", f_rd_valid, 1'b0);
`ifdef IPSXB_FIFO_ERR_FLAG_EN
        chk("rst9.std_underflow",  s_unf, 1'b1);
        chk("rst9.fwft_underflow", f_unf, 1'b1);
`endif

        // ---- randomized traffic against the model ----
        wp = 50; rp = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
                af_thresh = 5'($urandom_range(0, DEPTH));
                ae_thresh = 5'($urandom_range(0, DEPTH));
            end
            rst       = ($urandom_range(0, 399) == 0);
            s_w_en    = ($urandom_range(0, 99) < wp);
            s_r_en    = ($urandom_range(0, 99) < rp);
            s_wr_data = 8'($urandom);
            f_w_en    = ($urandom_range(0, 99) < wp);
            f_r_en    = ($urandom_range(0, 99) < rp);
            f_wr_data = 8'($urandom);
            step();
        end
        rst = 0; idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ipsxb_sync_fifo_v2_0
`default_nettype wire
